// File: rtl/ml_kl_arbiter_pkg.sv
// Shared KLink/MLink definitions: FSM encodings, id layout defaults and
// the request-size to burst-length helper.
package mlink_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int ID_W        = 5;
  localparam int TAG_LSB_DEF = 3;

  // Beats of 64 bits needed to move (1<<size) bytes; dataless requests are one beat.
  function automatic int unsigned beat_count(input logic den, input logic [2:0] size);
    int unsigned bytes_v;
    bytes_v = 32'd1 << size;
    if (!den || bytes_v < 32'd8) begin
      return 32'd1;
    end
    return bytes_v / 32'd8;
  endfunction

endpackage

// File: rtl/ml_kl_arbiter_if.sv
// Bundle of the requester-side and transceiver-side KLink signals around
// the arbiter. The master modport is the arbiter's view; slave is the
// surrounding clients plus transceiver.
interface ml_kl_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ*32-1:0] req_tx_addr;
  logic [NUM_REQ-1:0]    req_tx_den;
  logic [NUM_REQ*64-1:0] req_tx_data;
  logic [NUM_REQ*3-1:0]  req_tx_size;
  logic [NUM_REQ*5-1:0]  req_tx_id;
  logic [NUM_REQ-1:0]    req_tx_valid;
  logic [NUM_REQ-1:0]    req_tx_ready;

  logic [31:0]           req_rx_addr;
  logic [63:0]           req_rx_data;
  logic                  req_rx_den;
  logic [2:0]            req_rx_size;
  logic [4:0]            req_rx_id;
  logic [NUM_REQ-1:0]    req_rx_valid;
  logic [NUM_REQ-1:0]    req_rx_ready;

  logic [31:0]           kl_tx_addr;
  logic                  kl_tx_den;
  logic [63:0]           kl_tx_data;
  logic [2:0]            kl_tx_size;
  logic [4:0]            kl_tx_id;
  logic                  kl_tx_valid;
  logic                  kl_tx_ready;

  logic [31:0]           kl_rx_addr;
  logic [63:0]           kl_rx_data;
  logic                  kl_rx_den;
  logic [2:0]            kl_rx_size;
  logic [4:0]            kl_rx_id;
  logic                  kl_rx_valid;
  logic                  kl_rx_ready;

  modport master (
    input  req_tx_addr, req_tx_den, req_tx_data, req_tx_size, req_tx_id, req_tx_valid,
    output req_tx_ready,
    output req_rx_addr, req_rx_data, req_rx_den, req_rx_size, req_rx_id, req_rx_valid,
    input  req_rx_ready,
    output kl_tx_addr, kl_tx_den, kl_tx_data, kl_tx_size, kl_tx_id, kl_tx_valid,
    input  kl_tx_ready,
    input  kl_rx_addr, kl_rx_data, kl_rx_den, kl_rx_size, kl_rx_id, kl_rx_valid,
    output kl_rx_ready
  );

  modport slave (
    output req_tx_addr, req_tx_den, req_tx_data, req_tx_size, req_tx_id, req_tx_valid,
    input  req_tx_ready,
    input  req_rx_addr, req_rx_data, req_rx_den, req_rx_size, req_rx_id, req_rx_valid,
    output req_rx_ready,
    input  kl_tx_addr, kl_tx_den, kl_tx_data, kl_tx_size, kl_tx_id, kl_tx_valid,
    output kl_tx_ready,
    output kl_rx_addr, kl_rx_data, kl_rx_den, kl_rx_size, kl_rx_id, kl_rx_valid,
    input  kl_rx_ready
  );
endinterface

// File: rtl/ml_kl_arbiter_rr_pick.sv
// Round-robin priority selector: returns the first set valid at or after
// ptr, wrapping modulo NUM_REQ. Purely combinational.
module ml_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     sum;

  // Rotate so ptr sits at bit 0, then take the lowest set offset
  always_comb begin
    rot   = NUM_REQ'({valid, valid} >> ptr);
    found = 1'b0;
    sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDX_W+1)'(k);
      end
    end
    if (sum >= (IDX_W+1)'(NUM_REQ)) begin
      sum = sum - (IDX_W+1)'(NUM_REQ);
    end
    idx = sum[IDX_W-1:0];
  end
endmodule

// File: rtl/ml_kl_arbiter.sv
// Shares the KLink TX port among NUM_REQ requesters with burst-holding
// round-robin arbitration, tags outgoing ids with the requester index and
// routes RX responses back by that tag.
module ml_kl_arbiter
  import mlink_pkg::*;
#(
  parameter int NUM_REQ         = 3,
  parameter int TAG_LSB         = TAG_LSB_DEF,
  parameter int MAX_BURST_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  ml_kl_arbiter_if.master bus
);
  localparam int TAG_W = ID_W - TAG_LSB;
  typedef logic [MAX_BURST_WIDTH-1:0] cnt_t;

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     grant_q, grant_d;
  logic [TAG_W-1:0]     rr_ptr_q, rr_ptr_d;
  cnt_t                 cnt_q, cnt_d;
  logic                 err_tag_q, err_tag_d;

  logic [31:0]          hdr_addr_q, hdr_addr_d;
  logic                 hdr_den_q, hdr_den_d;
  logic [2:0]           hdr_size_q, hdr_size_d;
  logic [TAG_LSB-1:0]   hdr_id_q, hdr_id_d;

  logic [TAG_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 pick_den;
  logic [2:0]           pick_size;
  int unsigned          pick_beats;

  logic                 g_valid;
  logic [NUM_REQ-1:0]   tx_ready;
  logic [TAG_W-1:0]     rx_tag;
  logic [NUM_REQ-1:0]   rx_valid;
  logic                 rx_ready;

  ml_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_W)
  ) u_pick (
    .valid (bus.req_tx_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign pick_den   = bus.req_tx_den[pick_idx];
  assign pick_size  = bus.req_tx_size[3*pick_idx +: 3];
  assign pick_beats = beat_count(pick_den, pick_size);
  assign g_valid    = bus.req_tx_valid[grant_q];

  // Arbitration FSM: pick a requester when idle, then hold it for the whole burst
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    hdr_addr_d = hdr_addr_q;
    hdr_den_d  = hdr_den_q;
    hdr_size_d = hdr_size_q;
    hdr_id_d   = hdr_id_q;
    tx_ready   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_BUSY;
          grant_d    = pick_idx;
          cnt_d      = cnt_t'(pick_beats);
          hdr_addr_d = bus.req_tx_addr[32*pick_idx +: 32];
          hdr_den_d  = pick_den;
          hdr_size_d = pick_size;
          hdr_id_d   = bus.req_tx_id[5*pick_idx +: TAG_LSB];
        end
      end
      ST_BUSY: begin
        tx_ready[grant_q] = bus.kl_tx_ready;
        if (g_valid && bus.kl_tx_ready) begin
          cnt_d = cnt_q - cnt_t'(1);
          // A counter loaded with 0 stands for a full 2^MAX_BURST_WIDTH-beat burst
          if (cnt_q == cnt_t'(1)) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant_q == TAG_W'(NUM_REQ - 1)) ? '0 : grant_q + TAG_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      err_tag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      err_tag_q <= err_tag_d;
    end
  end

  // First-beat header capture; data path carries no reset
  always_ff @(posedge clk) begin
    hdr_addr_q <= hdr_addr_d;
    hdr_den_q  <= hdr_den_d;
    hdr_size_q <= hdr_size_d;
    hdr_id_q   <= hdr_id_d;
  end

  assign bus.req_tx_ready = tx_ready;
  assign bus.kl_tx_valid  = (state_q == ST_BUSY) && g_valid;
  assign bus.kl_tx_addr   = hdr_addr_q;
  assign bus.kl_tx_den    = hdr_den_q;
  assign bus.kl_tx_size   = hdr_size_q;
  assign bus.kl_tx_id     = {grant_q, hdr_id_q};
  assign bus.kl_tx_data   = bus.req_tx_data[64*grant_q +: 64];

  assign rx_tag = bus.kl_rx_id[ID_W-1:TAG_LSB];

  // RX steering by id tag; unknown tags are drained and flagged
  always_comb begin
    rx_valid  = '0;
    rx_ready  = 1'b1;
    err_tag_d = err_tag_q;
    if (int'(rx_tag) < NUM_REQ) begin
      rx_valid[rx_tag] = bus.kl_rx_valid;
      rx_ready         = bus.req_rx_ready[rx_tag];
    end else begin
      err_tag_d = err_tag_q | bus.kl_rx_valid;
    end
  end

  assign bus.req_rx_valid = rx_valid;
  assign bus.kl_rx_ready  = rx_ready;
  assign bus.req_rx_addr  = bus.kl_rx_addr;
  assign bus.req_rx_data  = bus.kl_rx_data;
  assign bus.req_rx_den   = bus.kl_rx_den;
  assign bus.req_rx_size  = bus.kl_rx_size;
  assign bus.req_rx_id    = {TAG_W'(0), bus.kl_rx_id[TAG_LSB-1:0]};

  // Burst lengths beyond the counter range are illegal requests
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_IDLE && pick_found) begin
      assert (pick_beats <= (32'd1 << MAX_BURST_WIDTH));
    end
  end

endmodule

// File: tb/tb_ml_kl_arbiter.sv
// Directed bench for ml_kl_arbiter: arbitration order, burst holding,
// stalls, RX routing and mid-burst reset.
module tb_ml_kl_arbiter;
  import mlink_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ml_kl_arbiter_if #(.NUM_REQ(3)) bus ();

  ml_kl_arbiter #(
    .NUM_REQ         (3),
    .TAG_LSB         (3),
    .MAX_BURST_WIDTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic den,
                         input logic [2:0] sz, input logic [2:0] id, input logic v);
    bus.req_tx_addr[32*i +: 32] = a;
    bus.req_tx_den[i]           = den;
    bus.req_tx_size[3*i +: 3]   = sz;
    bus.req_tx_id[5*i +: 5]     = {2'b00, id};
    bus.req_tx_data[64*i +: 64] = 64'hD000_0000_0000_0000 + 64'(i);
    bus.req_tx_valid[i]         = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    #1;
    n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d exp %0d", dut.state_q, ST_IDLE); end
    n_cmp++; if (dut.grant_q !== 2'd0) begin n_err++; $display("FAIL rst_grant: got %0d exp 0", dut.grant_q); end
    n_cmp++; if (dut.rr_ptr_q !== 2'd0) begin n_err++; $display("FAIL rst_rr_ptr: got %0d exp 0", dut.rr_ptr_q); end
    n_cmp++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL rst_cnt: got %0d exp 0", dut.cnt_q); end
    n_cmp++; if (bus.req_tx_ready !== 3'b000) begin n_err++; $display("FAIL rst_req_tx_ready: got %b exp 000", bus.req_tx_ready); end
    n_cmp++; if (bus.kl_tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_kl_tx_valid: got %b exp 0", bus.kl_tx_valid); end
    n_cmp++; if (bus.req_rx_valid !== 3'b000) begin n_err++; $display("FAIL rst_req_rx_valid: got %b exp 000", bus.req_rx_valid); end
    rst = 1'b0;
  endtask

  task automatic test_dataless_single();
    set_req(0, 32'h8000_0000, 1'b0, 3'd3, 3'b101, 1'b1);
    bus.kl_tx_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req_tx_ready !== 3'b000) begin n_err++; $display("FAIL t1_idle_ready: got %b exp 000", bus.req_tx_ready); end
    n_cmp++; if (bus.kl_tx_valid !== 1'b0) begin n_err++; $display("FAIL t1_idle_valid: got %b exp 0", bus.kl_tx_valid); end
    step();
    #1;
    n_cmp++; if (bus.kl_tx_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid: got %b exp 1", bus.kl_tx_valid); end
    n_cmp++; if (bus.kl_tx_id !== 5'b00101) begin n_err++; $display("FAIL t1_id: got %b exp 00101", bus.kl_tx_id); end
    n_cmp++; if (bus.kl_tx_addr !== 32'h8000_0000) begin n_err++; $display("FAIL t1_addr: got %h exp 80000000", bus.kl_tx_addr); end
    n_cmp++; if (bus.req_tx_ready !== 3'b001) begin n_err++; $display("FAIL t1_ready: got %b exp 001", bus.req_tx_ready); end
    step();
    bus.req_tx_valid[0] = 1'b0;
    #1;
    n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL t1_one_beat_state: got %0d exp %0d", dut.state_q, ST_IDLE); end
    n_cmp++; if (bus.kl_tx_valid !== 1'b0) begin n_err++; $display("FAIL t1_after_valid: got %b exp 0", bus.kl_tx_valid); end
    n_cmp++; if (dut.rr_ptr_q !== 2'd1) begin n_err++; $display("FAIL t1_rr_ptr: got %0d exp 1", dut.rr_ptr_q); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_v;
    int          exp_tag [11];
    int          sent [3];
    logic [4:0]  exp_id;
    int          t;
    exp_v   = 11'b01111011110;
    exp_tag = '{0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 0};
    sent    = '{0, 0, 0};
    set_req(1, 32'h1000_0040, 1'b1, 3'd5, 3'b010, 1'b1);
    set_req(2, 32'h2000_0080, 1'b1, 3'd5, 3'b011, 1'b1);
    bus.kl_tx_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) begin
        step();
        for (int i = 1; i < 3; i++) if (sent[i] >= 4) bus.req_tx_valid[i] = 1'b0;
      end
      #1;
      n_cmp++; if (bus.kl_tx_valid !== exp_v[c]) begin n_err++; $display("FAIL t2_valid c%0d: got %b exp %b", c, bus.kl_tx_valid, exp_v[c]); end
      if (exp_v[c]) begin
        exp_id = (exp_tag[c] == 1) ? 5'b01010 : 5'b10011;
        n_cmp++; if (bus.kl_tx_id !== exp_id) begin n_err++; $display("FAIL t2_id c%0d: got %b exp %b", c, bus.kl_tx_id, exp_id); end
        n_cmp++; if (bus.kl_tx_data !== 64'hD000_0000_0000_0000 + 64'(exp_tag[c])) begin n_err++; $display("FAIL t2_data c%0d: got %h", c, bus.kl_tx_data); end
        n_cmp++; if (bus.req_tx_ready !== 3'(1 << exp_tag[c])) begin n_err++; $display("FAIL t2_ready c%0d: got %b exp %b", c, bus.req_tx_ready, 3'(1 << exp_tag[c])); end
      end else begin
        n_cmp++; if (bus.req_tx_ready !== 3'b000) begin n_err++; $display("FAIL t2_bubble_ready c%0d: got %b exp 000", c, bus.req_tx_ready); end
      end
      if (bus.kl_tx_valid && bus.kl_tx_ready) begin
        t = int'(bus.kl_tx_id[4:3]);
        if (t < 3) sent[t]++;
      end
    end
    n_cmp++; if (sent[1] != 4 || sent[2] != 4) begin n_err++; $display("FAIL t2_beats: got %0d/%0d exp 4/4", sent[1], sent[2]); end
    n_cmp++; if (dut.rr_ptr_q !== 2'd0) begin n_err++; $display("FAIL t2_rr_ptr: got %0d exp 0", dut.rr_ptr_q); end
  endtask

  task automatic test_round_robin();
    int order [$];
    for (int i = 0; i < 3; i++) set_req(i, 32'h3000_0000 + 32'(i * 8), 1'b0, 3'd3, 3'(i), 1'b1);
    bus.kl_tx_ready = 1'b1;
    for (int c = 0; c < 40 && order.size() < 6; c++) begin
      if (c > 0) step();
      #1;
      if (bus.kl_tx_valid && bus.kl_tx_ready) order.push_back(int'(bus.kl_tx_id[4:3]));
    end
    step();
    bus.req_tx_valid = 3'b000;
    #1;
    n_cmp++; if (order.size() != 6) begin n_err++; $display("FAIL t3_count: got %0d exp 6", order.size()); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (k >= order.size()) begin n_err++; $display("FAIL t3_order k%0d: got none exp %0d", k, k % 3); end
      else if (order[k] != k % 3) begin n_err++; $display("FAIL t3_order k%0d: got %0d exp %0d", k, order[k], k % 3); end
    end
    n_cmp++; if (dut.rr_ptr_q !== 2'd0) begin n_err++; $display("FAIL t3_rr_ptr: got %0d exp 0", dut.rr_ptr_q); end
  endtask

  task automatic test_stall_hold();
    logic [8:0] v0;
    logic [8:0] rdy;
    v0  = 9'b111110011;
    rdy = 9'b101010101;
    set_req(0, 32'h4000_0000, 1'b1, 3'd5, 3'b001, 1'b1);
    set_req(1, 32'h4100_0000, 1'b0, 3'd3, 3'b001, 1'b1);
    set_req(2, 32'h4200_0000, 1'b0, 3'd3, 3'b001, 1'b1);
    bus.kl_tx_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req_tx_ready !== 3'b000) begin n_err++; $display("FAIL t4_idle_ready: got %b exp 000", bus.req_tx_ready); end
    for (int b = 0; b < 9; b++) begin
      step();
      bus.req_tx_valid[0] = v0[b];
      bus.kl_tx_ready     = rdy[b];
      #1;
      n_cmp++; if (dut.state_q !== ST_BUSY || dut.grant_q !== 2'd0) begin n_err++; $display("FAIL t4_hold b%0d: got state %0d grant %0d exp 1/0", b, dut.state_q, dut.grant_q); end
      n_cmp++; if (bus.kl_tx_valid !== v0[b]) begin n_err++; $display("FAIL t4_valid b%0d: got %b exp %b", b, bus.kl_tx_valid, v0[b]); end
      n_cmp++; if (bus.req_tx_ready !== {2'b00, rdy[b]}) begin n_err++; $display("FAIL t4_ready b%0d: got %b exp %b", b, bus.req_tx_ready, {2'b00, rdy[b]}); end
    end
    step();
    bus.req_tx_valid = 3'b000;
    bus.kl_tx_ready  = 1'b1;
    #1;
    n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL t4_end_state: got %0d exp %0d", dut.state_q, ST_IDLE); end
    n_cmp++; if (dut.rr_ptr_q !== 2'd1) begin n_err++; $display("FAIL t4_rr_ptr: got %0d exp 1", dut.rr_ptr_q); end
  endtask

  task automatic test_rx_route();
    bus.kl_rx_addr   = 32'hCAFE_0010;
    bus.kl_rx_data   = 64'h0123_4567_89AB_CDEF;
    bus.kl_rx_den    = 1'b1;
    bus.kl_rx_size   = 3'd4;
    bus.kl_rx_id     = 5'b10011;
    bus.kl_rx_valid  = 1'b1;
    bus.req_rx_ready = 3'b011;
    #1;
    n_cmp++; if (bus.req_rx_valid !== 3'b100) begin n_err++; $display("FAIL t5_valid: got %b exp 100", bus.req_rx_valid); end
    n_cmp++; if (bus.req_rx_id !== 5'b00011) begin n_err++; $display("FAIL t5_id: got %b exp 00011", bus.req_rx_id); end
    n_cmp++; if (bus.kl_rx_ready !== 1'b0) begin n_err++; $display("FAIL t5_stall: got %b exp 0", bus.kl_rx_ready); end
    n_cmp++; if (bus.req_rx_addr !== 32'hCAFE_0010 || bus.req_rx_data !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL t5_payload: got %h %h", bus.req_rx_addr, bus.req_rx_data); end
    n_cmp++; if (bus.req_rx_den !== 1'b1 || bus.req_rx_size !== 3'd4) begin n_err++; $display("FAIL t5_den_size: got %b %0d exp 1 4", bus.req_rx_den, bus.req_rx_size); end
    bus.req_rx_ready = 3'b100;
    #1;
    n_cmp++; if (bus.kl_rx_ready !== 1'b1) begin n_err++; $display("FAIL t5_release: got %b exp 1", bus.kl_rx_ready); end
    bus.kl_rx_id     = 5'b00110;
    bus.req_rx_ready = 3'b110;
    #1;
    n_cmp++; if (bus.req_rx_valid !== 3'b001 || bus.kl_rx_ready !== 1'b0) begin n_err++; $display("FAIL t5_tag0: got %b/%b exp 001/0", bus.req_rx_valid, bus.kl_rx_ready); end
    n_cmp++; if (dut.err_tag_q !== 1'b0) begin n_err++; $display("FAIL t5_err_clear: got %b exp 0", dut.err_tag_q); end
    bus.kl_rx_id     = 5'b11010;
    bus.req_rx_ready = 3'b000;
    #1;
    n_cmp++; if (bus.req_rx_valid !== 3'b000 || bus.kl_rx_ready !== 1'b1) begin n_err++; $display("FAIL t5_sink: got %b/%b exp 000/1", bus.req_rx_valid, bus.kl_rx_ready); end
    step();
    bus.kl_rx_valid = 1'b0;
    #1;
    n_cmp++; if (dut.err_tag_q !== 1'b1) begin n_err++; $display("FAIL t5_err_sticky: got %b exp 1", dut.err_tag_q); end
  endtask

  task automatic test_reset_mid_burst();
    set_req(0, 32'h5000_0000, 1'b1, 3'd5, 3'b100, 1'b1);
    bus.kl_tx_ready = 1'b1;
    #1;
    step();
    #1;
    n_cmp++; if (bus.kl_tx_valid !== 1'b1 || dut.grant_q !== 2'd0) begin n_err++; $display("FAIL t6_beat1: got %b grant %0d exp 1/0", bus.kl_tx_valid, dut.grant_q); end
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.kl_tx_valid !== 1'b1) begin n_err++; $display("FAIL t6_beat2: got %b exp 1", bus.kl_tx_valid); end
    step();
    rst = 1'b0;
    bus.req_tx_valid[0] = 1'b0;
    set_req(1, 32'h6000_0000, 1'b0, 3'd3, 3'b111, 1'b1);
    #1;
    n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL t6_abort_state: got %0d exp %0d", dut.state_q, ST_IDLE); end
    n_cmp++; if (bus.req_tx_ready !== 3'b000 || bus.kl_tx_valid !== 1'b0) begin n_err++; $display("FAIL t6_abort_outs: got %b/%b exp 000/0", bus.req_tx_ready, bus.kl_tx_valid); end
    n_cmp++; if (dut.rr_ptr_q !== 2'd0 || dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL t6_abort_regs: got ptr %0d cnt %0d exp 0/0", dut.rr_ptr_q, dut.cnt_q); end
    step();
    #1;
    n_cmp++; if (dut.grant_q !== 2'd1 || bus.kl_tx_id !== 5'b01111) begin n_err++; $display("FAIL t6_regrant: got grant %0d id %b exp 1/01111", dut.grant_q, bus.kl_tx_id); end
    n_cmp++; if (bus.req_tx_ready !== 3'b010 || bus.kl_tx_addr !== 32'h6000_0000) begin n_err++; $display("FAIL t6_regrant_bus: got %b %h exp 010 60000000", bus.req_tx_ready, bus.kl_tx_addr); end
    step();
    bus.req_tx_valid[1] = 1'b0;
    #1;
    n_cmp++; if (dut.state_q !== ST_IDLE || dut.rr_ptr_q !== 2'd2) begin n_err++; $display("FAIL t6_done: got state %0d ptr %0d exp 0/2", dut.state_q, dut.rr_ptr_q); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.req_tx_addr  = '0;
    bus.req_tx_den   = '0;
    bus.req_tx_data  = '0;
    bus.req_tx_size  = '0;
    bus.req_tx_id    = '0;
    bus.req_tx_valid = '0;
    bus.req_rx_ready = '0;
    bus.kl_tx_ready  = 1'b0;
    bus.kl_rx_addr   = '0;
    bus.kl_rx_data   = '0;
    bus.kl_rx_den    = 1'b0;
    bus.kl_rx_size   = '0;
    bus.kl_rx_id     = '0;
    bus.kl_rx_valid  = 1'b0;
    test_reset();
    test_dataless_single();
    test_back_to_back();
    test_round_robin();
    test_stall_hold();
    test_rx_route();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ml_kl_arbiter.md
Name: ml_kl_arbiter

Overview:
- Shares the single KLink generic TX port of the MLink transceiver among NUM_REQ requesters (e.g. icache refill, dcache, uncached I/O).
- Arbitrates round-robin and holds the grant for a whole burst.
- Tags each request's id with the requester index, and routes KLink RX responses back to the owning requester by that tag.
- Sits between the memory-side clients and the transceiver.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..4.
- TAG_LSB, 3, first id bit used as the requester tag. id[4:TAG_LSB] holds the tag; id[TAG_LSB-1:0] is owned by the requester.
- MAX_BURST_WIDTH, 4, burst counter width; up to 16 beats of 64 bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_tx_addr  in  NUM_REQ*32  per-requester address; slice i is bits [32i+31:32i]
- req_tx_den  in  NUM_REQ  per-requester data-enable
- req_tx_data  in  NUM_REQ*64  per-requester write data
- req_tx_size  in  NUM_REQ*3  log2 byte size
- req_tx_id  in  NUM_REQ*5  requester id; only bits below TAG_LSB are used
- req_tx_valid  in  NUM_REQ  request valid
- req_tx_ready  out  NUM_REQ  request accepted
- req_rx_addr  out  32  broadcast response address
- req_rx_data  out  64  broadcast response data
- req_rx_den  out  1  broadcast response data-enable
- req_rx_size  out  3  broadcast response size
- req_rx_id  out  5  response id with the tag bits zeroed
- req_rx_valid  out  NUM_REQ  one-hot response valid
- req_rx_ready  in  NUM_REQ  response ready
- kl_tx_addr/den/data/size/id/valid  out  32/1/64/3/5/1  to transceiver TX
- kl_tx_ready  in  1  from transceiver
- kl_rx_addr/data/den/size/id/valid  in  32/64/1/3/5/1  from transceiver RX
- kl_rx_ready  out  1  to transceiver

Behaviour:
- Reset values: state=ST_IDLE, grant=0, rr_ptr=0, beat counter=0. All outputs 0: req_tx_ready, kl_tx_valid, req_rx_valid. A reset mid-burst aborts to ST_IDLE in the next cycle with no further beats forwarded.
- Beat count for a data request: beats = max(1, (1<<size)/8), computed as a MAX_BURST_WIDTH-bit value. A dataless request is always 1 beat.
  - Subsequent beats arrive as further valid/ready transfers on the same requester port.
  - Only the data field is meaningful on subsequent beats; the header fields of the first beat are registered.
- ST_IDLE:
  - If any req_tx_valid is set, pick the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register grant=i, load the beat counter, go to ST_BUSY. Arbitration latency is exactly 1 cycle.
  - No ready is asserted in ST_IDLE.
- ST_BUSY:
  - kl_tx_valid = req_tx_valid[grant] and req_tx_ready[grant] = kl_tx_ready. All other readies are 0.
  - kl_tx_addr/den/size come from the granted requester.
  - kl_tx_id = {grant, req_tx_id[grant][TAG_LSB-1:0]}.
  - Each kl_tx_valid&&kl_tx_ready handshake decrements the counter.
  - On the handshake where the counter reaches 0: go to ST_IDLE and set rr_ptr = grant+1 (wrapping). The next arbitration happens in the following cycle, so there is one idle bubble between bursts.
  - The grant never changes mid-burst, even if the granted valid drops.
- RX routing is combinational:
  - tag = kl_rx_id[4:TAG_LSB].
  - req_rx_valid[tag] = kl_rx_valid; kl_rx_ready = req_rx_ready[tag].
  - A tag >= NUM_REQ is sunk: kl_rx_ready=1, no valid asserted, sticky err_tag register set (internal, visible in simulation).
- RX and TX paths are independent; simultaneous TX arbitration and RX delivery are legal.
- Size values giving more than 2^MAX_BURST_WIDTH beats are illegal; this is asserted in simulation.

Decomposition:
- Shared package mlink_pkg (header mlink.vh): state encodings ST_IDLE/ST_BUSY, TAG_LSB default, the beat-count function (size to beats).
- One sub-module, ml_rr_pick: pure round-robin priority selector taking the valid vector and rr_ptr, returning index and found.

Test Plan:
- Req0 sends a dataless request, addr 0x8000_0000, id 3'b101 -> kl_tx_id=5'b00101 and exactly 1 beat; rr_ptr becomes 1.
- Req1 and req2 are both valid with size=5 data (4 beats); kl_tx_ready is held at 1 -> req1's 4 beats go out contiguously, one bubble, then req2's 4 beats; kl_tx_id tags are 01 then 10.
- All three requesters are valid continuously with 1-beat requests -> grant order 0,1,2,0,1,2; no requester is served twice before the others.
- kl_tx_ready toggles 1,0,1,0 during a 4-beat burst, and req0 drops valid for 2 cycles mid-burst -> the grant stays at 0 and no other requester's ready rises until the 4th beat.
- Incoming RX with id 5'b10011, den=1, size=4 -> only req_rx_valid[2]=1 and req_rx_id=5'b00011; holding req_rx_ready[2]=0 stalls kl_rx_ready.
- Reset asserted on the 2nd beat of a 4-beat burst -> the next cycle is ST_IDLE, all readies 0, rr_ptr=0; a new req1 request is granted afterwards.
